// File: rtl/execute_stage.sv
// MIPS EX stage with the EX/MEM pipeline register: operand forwarding, ALU
// control decode, ALU, branch-target adder and destination select.
module execute_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        inBranch,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic        inMemToReg,
    input  logic        inRegWrite,
    input  logic [9:0]  inPC,
    input  logic [31:0] inData1,
    input  logic [31:0] inData2,
    input  logic [31:0] signExtend,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [1:0]  aluOp,
    input  logic        aluSrc,
    input  logic        inRegDst,
    input  logic [1:0]  inForwardingA,
    input  logic [1:0]  inForwardingB,
    input  logic [31:0] outmux_WBEXE,
    input  logic [31:0] aluResult_MEMEXE,
    output logic [9:0]  outPC,
    output logic        zero,
    output logic [31:0] aluResult,
    output logic [31:0] outData2,
    output logic [4:0]  wr,
    output logic        outBranch,
    output logic        outMemRead,
    output logic        outMemWrite,
    output logic        outMemToReg,
    output logic        outRegWrite,
    output logic [9:0]  outCurrentPC
);

    logic [31:0] opA;
    logic [31:0] fwdB;
    logic [31:0] opB;
    logic [31:0] aluNext;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [9:0]  branchTarget;
    logic [4:0]  wrNext;

    assign shamt = signExtend[10:6];
    assign funct = signExtend[5:0];

    // Select 11 falls back to the register-file value, same as 00.
    always_comb begin
        opA = inData1;
        case (inForwardingA)
            2'b01:   opA = outmux_WBEXE;
            2'b10:   opA = aluResult_MEMEXE;
            default: opA = inData1;
        endcase
    end

    always_comb begin
        fwdB = inData2;
        case (inForwardingB)
            2'b01:   fwdB = outmux_WBEXE;
            2'b10:   fwdB = aluResult_MEMEXE;
            default: fwdB = inData2;
        endcase
    end

    assign opB = aluSrc ? signExtend : fwdB;

    always_comb begin
        aluNext = 32'd0;
        case (aluOp)
            2'b00: aluNext = opA + opB;
            2'b01: aluNext = opA - opB;
            2'b11: aluNext = opA | opB;
            default: begin
                case (funct)
                    6'b100000: aluNext = opA + opB;
                    6'b100010: aluNext = opA - opB;
                    6'b100100: aluNext = opA & opB;
                    6'b100101: aluNext = opA | opB;
                    6'b100110: aluNext = opA ^ opB;
                    6'b100111: aluNext = ~(opA | opB);
                    6'b101010: aluNext = {31'd0, $signed(opA) < $signed(opB)};
                    6'b000000: aluNext = opB << shamt;
                    6'b000010: aluNext = opB >> shamt;
                    default:   aluNext = 32'd0;
                endcase
            end
        endcase
    end

    // Word-addressed PC: the 10-bit add wraps naturally.
    assign branchTarget = inPC + signExtend[9:0];
    assign wrNext       = inRegDst ? rd : rt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            outPC        <= '0;
            zero         <= 1'b0;
            aluResult    <= '0;
            outData2     <= '0;
            wr           <= '0;
            outBranch    <= 1'b0;
            outMemRead   <= 1'b0;
            outMemWrite  <= 1'b0;
            outMemToReg  <= 1'b0;
            outRegWrite  <= 1'b0;
            outCurrentPC <= '0;
        end else begin
            outPC        <= branchTarget;
            zero         <= (aluNext == 32'd0);
            aluResult    <= aluNext;
            outData2     <= fwdB;
            wr           <= wrNext;
            outBranch    <= inBranch;
            outMemRead   <= inMemRead;
            outMemWrite  <= inMemWrite;
            outMemToReg  <= inMemToReg;
            outRegWrite  <= inRegWrite;
            outCurrentPC <= inPC;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed transactions push expected
// EX/MEM contents; a monitor pops and compares one edge later.
module tb_execute_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite;
    logic [9:0]  inPC;
    logic [31:0] inData1, inData2, signExtend;
    logic [4:0]  rt, rd;
    logic [1:0]  aluOp;
    logic        aluSrc, inRegDst;
    logic [1:0]  inForwardingA, inForwardingB;
    logic [31:0] outmux_WBEXE, aluResult_MEMEXE;
    logic [9:0]  outPC;
    logic        zero;
    logic [31:0] aluResult, outData2;
    logic [4:0]  wr;
    logic        outBranch, outMemRead, outMemWrite, outMemToReg, outRegWrite;
    logic [9:0]  outCurrentPC;

    typedef struct packed {
        logic [9:0]  pc;
        logic        z;
        logic [31:0] res;
        logic [31:0] d2;
        logic [4:0]  wr;
        logic [4:0]  flags;
        logic [9:0]  cpc;
    } exp_t;

    exp_t expQ[$];
    exp_t mon;
    int   passCount  = 0;
    int   checkCount = 0;
    int   txNum      = 0;

    execute_stage dut (
        .clock(clock), .reset(reset),
        .inBranch(inBranch), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .inMemToReg(inMemToReg), .inRegWrite(inRegWrite),
        .inPC(inPC), .inData1(inData1), .inData2(inData2),
        .signExtend(signExtend), .rt(rt), .rd(rd), .aluOp(aluOp),
        .aluSrc(aluSrc), .inRegDst(inRegDst),
        .inForwardingA(inForwardingA), .inForwardingB(inForwardingB),
        .outmux_WBEXE(outmux_WBEXE), .aluResult_MEMEXE(aluResult_MEMEXE),
        .outPC(outPC), .zero(zero), .aluResult(aluResult), .outData2(outData2),
        .wr(wr), .outBranch(outBranch), .outMemRead(outMemRead),
        .outMemWrite(outMemWrite), .outMemToReg(outMemToReg),
        .outRegWrite(outRegWrite), .outCurrentPC(outCurrentPC)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, ".outPC"}, {22'd0, outPC}, 32'd0);
        chk({tag, ".zero"}, {31'd0, zero}, 32'd0);
        chk({tag, ".aluResult"}, aluResult, 32'd0);
        chk({tag, ".outData2"}, outData2, 32'd0);
        chk({tag, ".wr"}, {27'd0, wr}, 32'd0);
        chk({tag, ".flags"}, {27'd0, outBranch, outMemRead, outMemWrite, outMemToReg, outRegWrite}, 32'd0);
        chk({tag, ".outCurrentPC"}, {22'd0, outCurrentPC}, 32'd0);
    endtask

    // Drive one instruction, record its expected EX/MEM contents, advance one cycle.
    task automatic tx(input logic [1:0] op, input logic src, input logic dst,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] se,
                      input logic [9:0] pc, input logic [4:0] rtA, input logic [4:0] rdA,
                      input logic [4:0] flags, input logic [31:0] wb, input logic [31:0] mem,
                      input logic [9:0] ePc, input logic eZ, input logic [31:0] eRes,
                      input logic [31:0] eD2, input logic [4:0] eWr);
        exp_t e;
        aluOp = op; aluSrc = src; inRegDst = dst;
        inForwardingA = fa; inForwardingB = fb;
        inData1 = d1; inData2 = d2; signExtend = se; inPC = pc;
        rt = rtA; rd = rdA;
        {inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite} = flags;
        outmux_WBEXE = wb; aluResult_MEMEXE = mem;
        e.pc = ePc; e.z = eZ; e.res = eRes; e.d2 = eD2; e.wr = eWr;
        e.flags = flags; e.cpc = pc;
        expQ.push_back(e);
        @(posedge clock);
        #2;
    endtask

    // Monitor: an entry pushed before this edge has been captured by it.
    always @(posedge clock) begin
        #1;
        if (expQ.size() > 0) begin
            mon = expQ.pop_front();
            txNum++;
            chk("outPC", {22'd0, outPC}, {22'd0, mon.pc});
            chk("zero", {31'd0, zero}, {31'd0, mon.z});
            chk("aluResult", aluResult, mon.res);
            chk("outData2", outData2, mon.d2);
            chk("wr", {27'd0, wr}, {27'd0, mon.wr});
            chk("flags", {27'd0, outBranch, outMemRead, outMemWrite, outMemToReg, outRegWrite},
                {27'd0, mon.flags});
            chk("outCurrentPC", {22'd0, outCurrentPC}, {22'd0, mon.cpc});
            $display("tx %0d: aluResult=0x%08h zero=%0b outPC=%0d wr=%0d outData2=0x%08h",
                     txNum, aluResult, zero, outPC, wr, outData2);
        end
    end

    initial begin
        // Arbitrary non-zero inputs while reset is held low.
        aluOp = 2'b10; aluSrc = 1'b0; inRegDst = 1'b1;
        inForwardingA = 2'b00; inForwardingB = 2'b00;
        inData1 = 32'hAAAA5555; inData2 = 32'h12345678; signExtend = 32'h00000020;
        inPC = 10'd77; rt = 5'd3; rd = 5'd4;
        {inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite} = 5'b11111;
        outmux_WBEXE = 32'h1; aluResult_MEMEXE = 32'h2;
        @(posedge clock);
        @(posedge clock);
        #1;
        chkAllZero("reset");
        $display("reset held: outputs checked for zero");
        #1;
        reset = 1'b1;

        // op  src dst fa     fb     d1            d2            se            pc    rt  rd  flags     wb          mem          ePc  eZ  eRes          eD2           eWr
        tx(2'b10, 0, 1, 2'b00, 2'b00, 32'd1,        32'd1,        32'h00006024, 10'd1, 13, 12, 5'b00001, 32'd3,      32'd4,       10'd37, 0, 32'd1,        32'd1,        12); // AND
        tx(2'b10, 0, 1, 2'b10, 2'b00, 32'd1,        32'd1,        32'h00006024, 10'd1, 13, 12, 5'b00001, 32'd3,      32'd4,       10'd37, 1, 32'd0,        32'd1,        12); // A from MEM
        tx(2'b10, 0, 1, 2'b00, 2'b01, 32'd1,        32'd1,        32'h00006024, 10'd1, 13, 12, 5'b00001, 32'd3,      32'd4,       10'd37, 0, 32'd1,        32'd3,        12); // B from WB
        tx(2'b10, 0, 1, 2'b11, 2'b10, 32'd1,        32'd1,        32'h00000025, 10'd1, 13, 12, 5'b00001, 32'd3,      32'd4,       10'd38, 0, 32'd5,        32'd4,        12); // OR, A sel 11
        tx(2'b00, 1, 0, 2'b00, 2'b00, 32'd100,      32'd1,        32'd8,        10'd1,  5, 12, 5'b01011, 32'd0,      32'd0,       10'd9,  0, 32'd108,      32'd1,         5); // lw
        tx(2'b00, 1, 0, 2'b00, 2'b00, 32'd200,      32'hDEADBEEF, 32'hFFFFFFFC, 10'd10, 7, 12, 5'b00100, 32'd0,      32'd0,       10'd6,  0, 32'd196,      32'hDEADBEEF,  7); // sw
        tx(2'b01, 0, 0, 2'b00, 2'b00, 32'd7,        32'd7,        32'd10,       10'd1020, 3, 9, 5'b10000, 32'd0,     32'd0,       10'd6,  1, 32'd0,        32'd7,         3); // beq wrap
        tx(2'b10, 0, 1, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1,        32'h0000002A, 10'd0, 3,  9, 5'b00001, 32'd0,      32'd0,       10'd42, 0, 32'd1,        32'd1,         9); // SLT -1<1
        tx(2'b10, 0, 1, 2'b00, 2'b00, 32'd1,        32'hFFFFFFFF, 32'h0000002A, 10'd0, 3,  9, 5'b00001, 32'd0,      32'd0,       10'd42, 1, 32'd0,        32'hFFFFFFFF,  9); // SLT 1<-1
        tx(2'b10, 0, 1, 2'b00, 2'b00, 32'd0,        32'h0000000F, 32'h00000100, 10'd0, 3,  9, 5'b00001, 32'd0,      32'd0,       10'd256,0, 32'h000000F0, 32'h0000000F,  9); // SLL 4
        tx(2'b10, 0, 1, 2'b00, 2'b00, 32'd0,        32'h80000000, 32'h00000102, 10'd0, 3,  9, 5'b00001, 32'd0,      32'd0,       10'd258,0, 32'h08000000, 32'h80000000,  9); // SRL 4
        tx(2'b10, 0, 1, 2'b00, 2'b00, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h00000027, 10'd0, 3,  9, 5'b00001, 32'd0,      32'd0,       10'd39, 0, 32'h0000000F, 32'h0F0F0F00,  9); // NOR
        tx(2'b10, 0, 1, 2'b00, 2'b00, 32'hFF00FF00, 32'h0FF00FF0, 32'h00000026, 10'd0, 3,  9, 5'b00001, 32'd0,      32'd0,       10'd38, 0, 32'hF0F0F0F0, 32'h0FF00FF0,  9); // XOR
        tx(2'b10, 0, 1, 2'b00, 2'b00, 32'd0,        32'd1,        32'h00000022, 10'd0, 3,  9, 5'b00001, 32'd0,      32'd0,       10'd34, 0, 32'hFFFFFFFF, 32'd1,         9); // SUB wrap
        tx(2'b10, 0, 1, 2'b00, 2'b00, 32'h7FFFFFFF, 32'd1,        32'h00000020, 10'd0, 3,  9, 5'b00001, 32'd0,      32'd0,       10'd32, 0, 32'h80000000, 32'd1,         9); // ADD overflow
        tx(2'b10, 0, 1, 2'b00, 2'b00, 32'd5,        32'd3,        32'h0000003F, 10'd0, 3,  9, 5'b00001, 32'd0,      32'd0,       10'd63, 1, 32'd0,        32'd3,         9); // bad funct
        tx(2'b11, 1, 0, 2'b00, 2'b00, 32'h12340000, 32'h00000055, 32'h00005678, 10'd0, 3,  9, 5'b00001, 32'd0,      32'd0,       10'd632,0, 32'h12345678, 32'h00000055,  3); // ori

        @(posedge clock);
        #2;
        chk("queueDrained", expQ.size(), 32'd0);

        // Asynchronous assertion mid-cycle must clear outputs without an edge.
        reset = 1'b0;
        #1;
        chkAllZero("asyncReset");
        $display("async reset: outputs checked for zero");
        @(posedge clock);
        #1;
        chkAllZero("resetHold");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name:
execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline, together with the EX/MEM pipeline register.
- Selects forwarded operands, decodes ALU control from aluOp/funct, and computes the ALU result, the zero flag, the branch target and the destination register.
- Registers all results plus the pass-through control flags toward the MEM stage.

Parameters:
- None. Widths are fixed: data 32, PC 10 (word-addressed), register address 5.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- inBranch, inMemRead, inMemWrite, inMemToReg, inRegWrite  in  1 each  control flags passed through to MEM/WB
- inPC  in  10  PC+1 of the instruction in EX
- inData1  in  32  register-file Rs value
- inData2  in  32  register-file Rt value
- signExtend  in  32  sign-extended instr[15:0]; bits [5:0] are funct
- rt  in  5  Rt address
- rd  in  5  Rd address
- aluOp  in  2  ALU operation class from the control unit
- aluSrc  in  1  1 = ALU B operand is signExtend; 0 = forwarded B
- inRegDst  in  1  1 = destination is rd; 0 = destination is rt
- inForwardingA  in  2  operand A forwarding select
- inForwardingB  in  2  operand B forwarding select
- outmux_WBEXE  in  32  write-back data (MEM/WB stage)
- aluResult_MEMEXE  in  32  ALU result currently in EX/MEM
- outPC  out  10  registered branch target
- zero  out  1  registered (ALU result == 0)
- aluResult  out  32  registered ALU result
- outData2  out  32  registered forwarded B operand (store data)
- wr  out  5  registered destination register address
- outBranch, outMemRead, outMemWrite, outMemToReg, outRegWrite  out  1 each  registered copies of the in* flags
- outCurrentPC  out  10  registered inPC

Behaviour:
- Reset (reset low, asynchronous): every output is 0 and stays 0 while reset is low.
- Latency: all outputs are registered and update on the rising clock edge. The combinational EX result for the current inputs appears after one edge.

Forwarding muxes:
- Operand A by inForwardingA: 00 = inData1, 01 = outmux_WBEXE, 10 = aluResult_MEMEXE, 11 = inData1.
- Forwarded B by inForwardingB: same encoding, using inData2 in place of inData1.
- ALU B = aluSrc ? signExtend : forwarded B.
- outData2 always takes the forwarded B, never signExtend.

ALU control:
- aluOp 00 = ADD (lw/sw/addi).
- aluOp 01 = SUB (beq).
- aluOp 11 = OR (ori).
- aluOp 10 = R-type, decoded by funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
  - 101010 SLT (signed; result 1 or 0)
  - 000000 SLL (B << signExtend[10:6])
  - 000010 SRL (B >> signExtend[10:6], logical)
  - any other funct gives a result of 0.

Arithmetic rules:
- ADD and SUB are 32-bit modulo 2^32; overflow is ignored and no exception is raised.
- zero = (ALU result == 32'd0).
- outPC = inPC + signExtend[9:0], modulo 1024 (wraps).
- wr = inRegDst ? rd : rt.

Pipeline behaviour:
- There is no stall or flush input; the register captures every cycle.
- When reset is released, capture starts at the next rising edge.

Test Plan:
1. Reset low for 2 cycles with arbitrary inputs -> all outputs 0. Release reset -> outputs follow the inputs after the next edge.
2. AND, no hazard: aluOp=10, aluSrc=0, inRegDst=1, inPC=1, inData1=1, inData2=1, signExtend=0x00006024, rt=13, rd=12, both forwarding selects=00 -> aluResult=1, zero=0, wr=12, outData2=1, outPC=37, outCurrentPC=1.
3. Same inputs with inForwardingA=10, aluResult_MEMEXE=4, outmux_WBEXE=3 -> aluResult=0 (4&1), zero=1.
4. Same inputs with inForwardingA=00, inForwardingB=01, outmux_WBEXE=3 -> aluResult=1 (1&3), outData2=3, zero=0.
5. lw: aluOp=00, aluSrc=1, inRegDst=0, inData1=100, signExtend=8, rt=5, inMemRead=1, inMemToReg=1, inRegWrite=1 -> aluResult=108, wr=5, flags propagated.
6. beq and SLT:
   - beq: aluOp=01, inData1=inData2=7, inBranch=1, inPC=1020, signExtend=10 -> zero=1, aluResult=0, outPC=6 (wrap), outBranch=1.
   - SLT: funct=101010, A=-1, B=1 -> aluResult=1.
